// File: rtl/dll_sar_ctrl.sv
// dll_sar_ctrl: SAR delay-code controller for a DLL. Runs a WIDTH-step binary search
// on the phase-detector result; define SAR_TRACK_EN to add +/-1 tracking with lock detection.
module dll_sar_ctrl #(
  parameter int WIDTH    = 10,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk4,
  input  logic             rst,
  input  logic             start,
  input  logic             comp,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_next,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_MID   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX   = {WIDTH{1'b1}};
  localparam logic [IW-1:0]    IDX_TOP = IW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IW-1:0]    idx_q, idx_d, idx_m1;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             locked_q, locked_d;

`ifdef SAR_TRACK_EN
  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);
  logic [3:0] cnt_q, cnt_d;
  logic       prev_q, prev_d;
  logic       sat;
`else
  // The lock threshold has no role when tracking is compiled out.
  logic [3:0] lock_cnt_unused;
  assign lock_cnt_unused = 4'(LOCK_CNT);
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    locked_d = locked_q;
    idx_m1   = idx_q - 1'b1;
`ifdef SAR_TRACK_EN
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    sat      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d      = Q_MID;
          idx_d    = IDX_TOP;
          locked_d = 1'b0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
`ifdef SAR_TRACK_EN
        prev_d = comp;
`endif
        if (idx_q != '0) begin
          // Lag means the trial bit overshot: drop it, then try the next lower bit.
          if (comp) q_d[idx_q] = 1'b0;
          q_d[idx_m1] = 1'b1;
          idx_d       = idx_m1;
        end else begin
          q_d[0] = ~comp;
          done_d = 1'b1;
`ifdef SAR_TRACK_EN
          cnt_d   = '0;
          state_d = S_TRACK;
`else
          locked_d = 1'b1;
          state_d  = S_IDLE;
`endif
        end
      end
`ifdef SAR_TRACK_EN
      S_TRACK: begin
        if (start) begin
          q_d      = Q_MID;
          idx_d    = IDX_TOP;
          locked_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SEARCH;
        end else begin
          sat = comp ? (q_q == '0) : (q_q == Q_MAX);
          if (!sat) q_d = comp ? (q_q - 1'b1) : (q_q + 1'b1);
          // Lock means the loop dithers one LSB around the edge without pinning at a rail.
          if (sat || (comp == prev_q)) cnt_d = '0;
          else if (cnt_q != LOCK_MAX)  cnt_d = cnt_q + 1'b1;
          prev_d   = comp;
          locked_d = (cnt_d == LOCK_MAX);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SEARCH);
  end

  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      q_q      <= Q_MID;
      idx_q    <= IDX_TOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
`ifdef SAR_TRACK_EN
      cnt_q    <= '0;
      prev_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      locked_q <= locked_d;
`ifdef SAR_TRACK_EN
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
`endif
    end
  end

  assign Q         = q_q;
  assign Q_next    = q_d;
  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dll_sar_ctrl.sv
// tb_dll_sar_ctrl: vector table, directed corner sequences and randomized traffic
// checked against a bit-by-bit arithmetic model of the search and tracking rules.
module tb_dll_sar_ctrl;

  localparam int W  = 10;
  localparam int LK = 4;
  localparam int unsigned MID  = 1 << (W - 1);
  localparam int unsigned QMAX = (1 << W) - 1;
`ifdef SAR_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic         clk4;
  logic         rst;
  logic         start;
  logic         comp;
  logic [W-1:0] Q;
  logic [W-1:0] Q_next;
  logic         busy;
  logic         done;
  logic         locked;
  logic [1:0]   state_dbg;

  dll_sar_ctrl #(.WIDTH(W), .LOCK_CNT(LK)) dut (
    .clk4      (clk4),
    .rst       (rst),
    .start     (start),
    .comp      (comp),
    .Q         (Q),
    .Q_next    (Q_next),
    .busy      (busy),
    .done      (done),
    .locked    (locked),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk4 = 1'b0;
  always #5 clk4 = ~clk4;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 searching, 2 tracking. The search result is simply the inverted
  // comparator history read MSB first; mid-search the next trial bit is set below it.
  int          m_mode, m_k, m_alt;
  int unsigned m_bits, m_q;
  bit          m_done, m_locked, m_prev;

  function automatic void model_reset();
    m_mode = 0; m_k = 0; m_bits = 0; m_q = MID;
    m_done = 1'b0; m_locked = 1'b0; m_alt = 0; m_prev = 1'b0;
  endfunction

  function automatic void model_edge(input bit s, input bit c);
    int target;
    m_done = 1'b0;
    if (s && (m_mode == 0 || m_mode == 2)) begin
      m_mode = 1; m_k = 0; m_bits = 0; m_q = MID; m_locked = 1'b0; m_alt = 0;
    end else if (m_mode == 1) begin
      m_bits = (m_bits << 1) | (c ? 0 : 1);
      m_k++;
      m_prev = c;
      if (m_k == W) begin
        m_q = m_bits;
        m_done = 1'b1;
        if (TRK) begin m_mode = 2; m_alt = 0; end
        else begin m_mode = 0; m_locked = 1'b1; end
      end else begin
        m_q = (m_bits << (W - m_k)) | (1 << (W - 1 - m_k));
      end
    end else if (m_mode == 2) begin
      target = c ? int'(m_q) - 1 : int'(m_q) + 1;
      if (target < 0 || target > int'(QMAX)) m_alt = 0;
      else begin
        m_q = target;
        m_alt = (c == m_prev) ? 0 : ((m_alt < LK) ? m_alt + 1 : LK);
      end
      m_prev = c;
      m_locked = (m_alt == LK);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; inputs change there, outputs are sampled 1 after the next edge.
  task automatic drive_cycle(input bit s, input bit c);
    logic [W-1:0] e;
    start = s;
    comp  = c;
    #1;
    model_edge(s, c);
    exp_q.push_back(W'(m_q));
    check("q_next", Q_next, m_q);
    @(posedge clk4);
    #1;
    e = exp_q.pop_front();
    check("q", Q, e);
    check("busy", busy, (m_mode == 1));
    check("done", done, m_done);
    check("locked", locked, m_locked);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk4);
    rst = 1'b1;
    #1;
    check("rst_q", Q, MID);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    model_reset();
    exp_q.delete();
    @(posedge clk4);
    #1;
    check("rst_hold_q", Q, MID);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          s;
    bit          c;
    int unsigned q;
    bit          b;
    bit          d;
    bit          l;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int done_at;
    int bias;
    int exp_trk_q[4];
    bit exp_trk_l[4];

    // Search with comparator history 1,0,1,0,0,0,0,0,0,1 -> 382.
    vecs[0]  = '{1'b1, 1'b0, 512, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 256, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 384, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 320, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 352, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 368, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 376, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 380, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 382, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 383, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 382, 1'b0, 1'b1, !TRK};
    vecs[11] = '{1'b0, 1'b0, (TRK ? 383 : 382), 1'b0, 1'b0, !TRK};

    rst = 1'b0; start = 1'b0; comp = 1'b0;
    model_reset();
    #2;
    do_reset();

    // After reset, stay idle with Q held until start.
    repeat (3) drive_cycle(1'b0, 1'($urandom_range(0, 1)));

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].s;
      comp  = vecs[i].c;
      #1;
      check("tbl_q_next", Q_next, vecs[i].q);
      @(posedge clk4);
      #1;
      check("tbl_q", Q, vecs[i].q);
      check("tbl_busy", busy, vecs[i].b);
      check("tbl_done", done, vecs[i].d);
      check("tbl_locked", locked, vecs[i].l);
    end

    // All-lead search saturates high.
    do_reset();
    done_seen = 0;
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < W; i++) drive_cycle(1'b0, 1'b0);
    check("allzero_q", Q, QMAX);
    check("allzero_done_cnt", done_seen, 1);

    if (TRK) begin
      exp_trk_q = '{1022, 1023, 1022, 1023};
      exp_trk_l = '{1'b0, 1'b0, 1'b0, 1'b1};
      drive_cycle(1'b0, 1'b0);
      check("trk_sat_q", Q, QMAX);
      check("trk_sat_locked", locked, 1'b0);
      for (int i = 0; i < 4; i++) begin
        drive_cycle(1'b0, 1'(i % 2 == 0));
        check("trk_alt_q", Q, exp_trk_q[i]);
        check("trk_alt_locked", locked, exp_trk_l[i]);
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        drive_cycle(1'b0, 1'($urandom_range(0, 1)));
        check("idle_hold_q", Q, QMAX);
        check("idle_hold_locked", locked, 1'b1);
        check("idle_state", state_dbg, 2'd0);
      end
      check("idle_done_cnt", done_seen, 1);
    end

    // All-lag search bottoms out.
    done_seen = 0;
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < W; i++) drive_cycle(1'b0, 1'b1);
    check("allone_q", Q, 0);
    check("allone_done_cnt", done_seen, 1);

    // Reset during the fifth search cycle aborts without done.
    do_reset();
    done_seen = 0;
    drive_cycle(1'b1, 1'b0);
    repeat (4) drive_cycle(1'b0, 1'($urandom_range(0, 1)));
    do_reset();
    repeat (3) drive_cycle(1'b0, 1'b0);
    check("abort_q", Q, MID);
    check("abort_done_cnt", done_seen, 0);

    // start held high through a search is ignored; done lands after exactly W edges.
    done_seen = 0;
    done_at = -1;
    drive_cycle(1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      drive_cycle(1'b1, 1'($urandom_range(0, 1)));
      if (done === 1'b1 && done_at < 0) done_at = i;
    end
    check("start_ignored_done_at", done_at, W - 1);
    check("start_ignored_done_cnt", done_seen, 1);

    // Randomized traffic against the model.
    bias = 2;
    for (int n = 0; n < 800; n++) begin
      bit s;
      bit c;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        case (m_mode)
          0:       s = ($urandom_range(0, 2) == 0);
          1:       s = ($urandom_range(0, 4) == 0);
          default: s = ($urandom_range(0, 39) == 0);
        endcase
        if (s && m_mode != 1) bias = $urandom_range(0, 3);
        if (m_mode == 2 && !s) c = m_prev ^ ($urandom_range(0, 4) != 0);
        else if (bias == 0)    c = 1'b0;
        else if (bias == 1)    c = 1'b1;
        else                   c = 1'($urandom_range(0, 1));
        drive_cycle(s, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dll_sar_ctrl.md
DLL_SAR_CTRL -- requirements
Module: dll_sar_ctrl

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the delay-code width (legal range 4..16).
REQ-002 Parameter LOCK_CNT, default 4, SHALL set the number of consecutive alternating comparator samples in TRACK required to assert locked (legal range 1..15).
REQ-003 clk4  input  1  SHALL be the only clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new binary search; sampled on clk4.
REQ-006 comp  input  1  SHALL be the phase-detector result: 1 = lag, 0 = lead.
REQ-007 Q  output  WIDTH  SHALL carry the registered delay code.
REQ-008 Q_next  output  WIDTH  SHALL carry the combinational next value of Q.
REQ-009 busy  output  1  SHALL be high while state is SEARCH.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle after the final search bit resolves.
REQ-011 locked  output  1  SHALL indicate loop lock per REQ-020/REQ-027.

Function
REQ-012 The block SHALL use three states: IDLE, SEARCH and TRACK, plus an internal bit index idx of width clog2(WIDTH).
REQ-013 In IDLE with start=1, the block SHALL load Q=1<<(WIDTH-1) and idx=WIDTH-1, clear locked, and enter SEARCH on the same edge.
REQ-014 In SEARCH with idx!=0: comp=1 SHALL clear Q[idx] and set Q[idx-1]; comp=0 SHALL set Q[idx-1]; in both cases idx decrements by 1.
REQ-015 In SEARCH with idx==0: Q[0] SHALL be set to ~comp, done SHALL pulse on the next cycle, and the state SHALL leave SEARCH.
REQ-016 A search SHALL take exactly WIDTH clk4 edges after the start edge, and done SHALL be high in the cycle following the last edge.
REQ-017 start SHALL be ignored in SEARCH; start in TRACK SHALL restart the search exactly as REQ-013 does.
REQ-018 In TRACK, comp=1 SHALL decrement Q by 1, saturating at 0, and comp=0 SHALL increment Q by 1, saturating at 2^WIDTH-1.
REQ-019 Q_next SHALL equal the value Q takes on the next edge for current inputs, including start restarts and saturation.
REQ-020 In TRACK, an alternation counter SHALL increment (saturating at LOCK_CNT) when comp differs from the previous sample, and SHALL clear when comp equals it or when Q saturates; locked SHALL equal (counter==LOCK_CNT).
REQ-021 In IDLE with start=0, Q and locked SHALL hold their values.

Reset
REQ-022 While rst=1, the block SHALL asynchronously force Q=1<<(WIDTH-1), idx=WIDTH-1, state=IDLE, busy=0, done=0, locked=0, and the alternation counter to 0.
REQ-023 Reset asserted mid-SEARCH or mid-TRACK SHALL abort the operation with no done pulse.
REQ-024 After rst deasserts, the block SHALL remain in IDLE until start=1.

Configuration
REQ-025 Macro SAR_TRACK_EN SHALL compile the TRACK state, the alternation counter and LOCK_CNT logic in or out.
REQ-026 With SAR_TRACK_EN defined, completion of a search SHALL enter TRACK with the counter at 0.
REQ-027 Without SAR_TRACK_EN, completion of a search SHALL return to IDLE; locked SHALL assert with done and hold until the next start or reset.

Verification
REQ-028 WIDTH=10, reset, start, then comp=0 for 10 cycles -> Q=1023, done pulse in cycle 11, busy high for cycles 1-10.
REQ-029 WIDTH=10, start, then comp=1 for 10 cycles -> Q=0, done pulse once.
REQ-030 WIDTH=10, start, then comp sequence 1,0,1,0,0,0,0,0,0,1 -> Q=0b0101111110 (382).
REQ-031 With SAR_TRACK_EN, after search to Q=1023, comp=0 -> Q stays at 1023, counter clears; then alternating comp=1,0,1,0 -> Q=1022,1023,1022,1023 and locked rises on the 4th alternation.
REQ-032 rst pulsed at search cycle 5 -> Q=512, busy=0, no done pulse; start during SEARCH -> ignored, search completes in 10 cycles.
REQ-033 Without SAR_TRACK_EN, search completes -> state IDLE, locked=1, and Q holds regardless of comp until the next start.
